// File: rtl/ib_issue_ctrl.sv
// Issue controller between the dual-FIFO instruction buffer and decode/issue.
// Holds one popped instruction pair and issues it as a pair or as two singles.
module ib_issue_ctrl #(
    parameter int DW         = 104,
    parameter bit DUAL_ISSUE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] ib_data1,
    input  logic [DW-1:0] ib_data2,
    input  logic [1:0]    ib_valid,
    output logic          get_data_req,
    input  logic          issue_ready,
    output logic [1:0]    issue_valid,
    output logic [DW-1:0] issue_data1,
    output logic [DW-1:0] issue_data2,
    output logic [31:0]   cnt_dual,
    output logic [31:0]   cnt_single,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_PAIR   = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    // Handshake: an issue transfers in a cycle where issue_valid != 00 and
    // issue_ready = 1; a pop transfers when get_data_req = 1 and ib_valid[0] = 1.

    state_t          state_q, state_d;
    logic [DW-1:0]   h1_q, h1_d;
    logic [DW-1:0]   h2_q, h2_d;
    logic [31:0]     cnt_dual_q, cnt_dual_d;
    logic [31:0]     cnt_single_q, cnt_single_d;

    logic [4:0]      h1_rd, h2_rd, h2_rj, h2_rk;
    logic            raw_dep;
    logic            hazard;
    logic [1:0]      valid_raw;
    logic            fire;
    logic            load;

    // Register fields sit in inst[14:0], i.e. entry bits [22:8].
    assign h1_rd = h1_q[12:8];
    assign h2_rd = h2_q[12:8];
    assign h2_rj = h2_q[17:13];
    assign h2_rk = h2_q[22:18];

    assign raw_dep = (h1_rd != 5'd0) &&
                     ((h2_rj == h1_rd) || (h2_rk == h1_rd) || (h2_rd == h1_rd));
    assign hazard  = !DUAL_ISSUE || h1_q[7] || h2_q[7] || raw_dep;

    always_comb begin
        valid_raw = 2'b00;
        case (state_q)
            S_PAIR:   valid_raw = hazard ? 2'b01 : 2'b11;
            S_SECOND: valid_raw = 2'b01;
            default:  valid_raw = 2'b00;
        endcase
    end

    assign issue_valid  = flush ? 2'b00 : valid_raw;
    assign fire         = issue_ready && (issue_valid != 2'b00);
    assign get_data_req = !flush && ((state_q == S_EMPTY) ||
                                     (fire && (state_q == S_SECOND)) ||
                                     (fire && (state_q == S_PAIR) && !hazard));
    assign load         = get_data_req && ib_valid[0];

    assign issue_data1 = (state_q == S_SECOND) ? h2_q : h1_q;
    assign issue_data2 = h2_q;
    assign cnt_dual    = cnt_dual_q;
    assign cnt_single  = cnt_single_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d      = state_q;
        h1_d         = h1_q;
        h2_d         = h2_q;
        cnt_dual_d   = cnt_dual_q;
        cnt_single_d = cnt_single_q;

        if (fire && (issue_valid == 2'b11)) cnt_dual_d   = cnt_dual_q + 32'd1;
        if (fire && (issue_valid == 2'b01)) cnt_single_d = cnt_single_q + 32'd1;

        if (flush) begin
            state_d = S_EMPTY;
        end else if (load) begin
            state_d = S_PAIR;
            h1_d    = ib_data1;
            h2_d    = ib_data2;
        end else if (fire) begin
            // A hazarded pair leaves h2 outstanding; any other fire drains.
            if (state_q == S_PAIR && hazard) state_d = S_SECOND;
            else                             state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_EMPTY;
            h1_q         <= '0;
            h2_q         <= '0;
            cnt_dual_q   <= '0;
            cnt_single_q <= '0;
        end else begin
            state_q      <= state_d;
            h1_q         <= h1_d;
            h2_q         <= h2_d;
            cnt_dual_q   <= cnt_dual_d;
            cnt_single_q <= cnt_single_d;
        end
    end

endmodule
